uart_verici_param: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the peripheral (cevre_birimleri) group.
- Configurable data width; runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
- Internal FIFO with valid/ready write handshake, so the core/bus side can queue bytes without waiting per frame.
- Drives the physical TX line and reports frame completion and FIFO status to the bus interface.

---
 rtl/uart_verici_param_pkg.sv | 20 ++
 rtl/uart_verici_fifo.sv | 64 ++++++
 rtl/uart_verici_param.sv | 159 +++++++++++++++
 tb/tb_uart_verici_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_verici_param_pkg.sv
// Shared encodings for the parametrised UART transmitter: parity modes,
// frame FSM states and a parity-enable helper.
package uart_verici_param_pkg;

  localparam logic [1:0] PARITE_YOK  = 2'd0;
  localparam logic [1:0] PARITE_CIFT = 2'd1;
  localparam logic [1:0] PARITE_TEK  = 2'd2;

  localparam logic [2:0] BOSTA  = 3'd0;
  localparam logic [2:0] BASLA  = 3'd1;
  localparam logic [2:0] VERI   = 3'd2;
  localparam logic [2:0] PARITE = 3'd3;
  localparam logic [2:0] DURMA  = 3'd4;

  // Mode 3 is an alias of "no parity".
  function automatic logic parite_etkin(input logic [1:0] mod);
    return (mod == PARITE_CIFT) || (mod == PARITE_TEK);
  endfunction

endpackage

// File: rtl/uart_verici_fifo.sv
// Synchronous FIFO with registered empty/full flags; writes are dropped
// when full and reads are ignored when empty.
module uart_verici_fifo #(
  parameter int GENISLIK = 8,
  parameter int DERINLIK = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [GENISLIK-1:0] veri_i,
  output logic [GENISLIK-1:0] veri_o,
  output logic                bos_o,
  output logic                dolu_o
);

  localparam int AW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] r_mem [DERINLIK];
  logic [AW-1:0]       r_yaz;
  logic [AW-1:0]       r_oku;
  logic [AW:0]         r_sayi;
  logic [AW:0]         w_sayi_n;
  logic                r_bos;
  logic                r_dolu;
  logic                w_push;
  logic                w_pop;

  assign w_push = push_i && !r_dolu;
  assign w_pop  = pop_i && !r_bos;

  always_comb begin
    w_sayi_n = r_sayi;
    if (w_push && !w_pop)
      w_sayi_n = r_sayi + (AW+1)'(1);
    else if (!w_push && w_pop)
      w_sayi_n = r_sayi - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_yaz  <= '0;
      r_oku  <= '0;
      r_sayi <= '0;
      r_bos  <= 1'b1;
      r_dolu <= 1'b0;
    end else begin
      if (w_push) r_yaz <= r_yaz + AW'(1);
      if (w_pop)  r_oku <= r_oku + AW'(1);
      r_sayi <= w_sayi_n;
      r_bos  <= (w_sayi_n == '0);
      r_dolu <= (w_sayi_n == (AW+1)'(DERINLIK));
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_yaz] <= veri_i;
  end

  assign veri_o = r_mem[r_oku];
  assign bos_o  = r_bos;
  assign dolu_o = r_dolu;

endmodule

// File: rtl/uart_verici_param.sv
// Parametrised UART transmitter: FIFO-fed frame FSM with runtime parity and
// stop-bit selection; configuration is latched when each frame starts.
module uart_verici_param
  import uart_verici_param_pkg::*;
#(
  parameter int VERI_BIT      = 8,
  parameter int FIFO_DERINLIK = 8,
  parameter int BAUD_GENISLIK = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     veri_gecerli_i,
  input  logic [VERI_BIT-1:0]      veri_i,
  output logic                     veri_hazir_o,
  input  logic [BAUD_GENISLIK-1:0] baud_div_i,
  input  logic [1:0]               parite_mod_i,
  input  logic                     durma_iki_i,
  output logic                     tx_o,
  output logic                     mesgul_o,
  output logic                     bitti_o,
  output logic                     fifo_bos_o,
  output logic                     fifo_dolu_o
);

  localparam int BW = $clog2(VERI_BIT);
  localparam logic [BW-1:0] SON_BIT = BW'(VERI_BIT - 1);

  function automatic logic parite_hesapla(input logic [VERI_BIT-1:0] d,
                                          input logic [1:0]          mod);
    return (^d) ^ (mod == PARITE_TEK);
  endfunction

  logic [VERI_BIT-1:0]      w_fifo_veri;
  logic                     w_bos;
  logic                     w_dolu;
  logic                     w_pop;
  logic                     w_bit_son;
  logic                     w_son_durma;
  logic [2:0]               r_durum;
  logic [BAUD_GENISLIK-1:0] r_baud;
  logic [BAUD_GENISLIK-1:0] r_p;
  logic [1:0]               r_pmod;
  logic                     r_iki;
  logic [BW-1:0]            r_bit;
  logic [VERI_BIT-1:0]      r_shift;
  logic                     r_parite;
  logic                     r_tx;
  logic                     r_mesgul;
  logic                     r_bitti;

  uart_verici_fifo #(.GENISLIK(VERI_BIT), .DERINLIK(FIFO_DERINLIK)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (veri_gecerli_i),
    .pop_i  (w_pop),
    .veri_i (veri_i),
    .veri_o (w_fifo_veri),
    .bos_o  (w_bos),
    .dolu_o (w_dolu)
  );

  assign w_bit_son   = (r_baud == r_p - BAUD_GENISLIK'(1));
  // r_bit counts stop periods in DURMA, so bit 0 marks the second stop.
  assign w_son_durma = (r_durum == DURMA) && w_bit_son && (!r_iki || r_bit[0]);
  assign w_pop       = !w_bos && ((r_durum == BOSTA) || w_son_durma);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum  <= BOSTA;
      r_baud   <= '0;
      r_bit    <= '0;
      r_p      <= BAUD_GENISLIK'(1);
      r_pmod   <= PARITE_YOK;
      r_iki    <= 1'b0;
      r_tx     <= 1'b1;
      r_mesgul <= 1'b0;
      r_bitti  <= 1'b0;
    end else begin
      r_bitti <= 1'b0;
      if (w_pop) begin
        r_durum  <= BASLA;
        r_baud   <= '0;
        r_tx     <= 1'b0;
        r_mesgul <= 1'b1;
        r_p      <= (baud_div_i == '0) ? BAUD_GENISLIK'(1) : baud_div_i;
        r_pmod   <= parite_mod_i;
        r_iki    <= durma_iki_i;
        if (w_son_durma) r_bitti <= 1'b1;
      end else begin
        case (r_durum)
          BOSTA: r_tx <= 1'b1;
          BASLA: begin
            if (w_bit_son) begin
              r_baud  <= '0;
              r_bit   <= '0;
              r_durum <= VERI;
              r_tx    <= r_shift[0];
            end else r_baud <= r_baud + BAUD_GENISLIK'(1);
          end
          VERI: begin
            if (w_bit_son) begin
              r_baud <= '0;
              if (r_bit == SON_BIT) begin
                r_bit <= '0;
                if (parite_etkin(r_pmod)) begin
                  r_durum <= PARITE;
                  r_tx    <= r_parite;
                end else begin
                  r_durum <= DURMA;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit <= r_bit + BW'(1);
                r_tx  <= r_shift[1];
              end
            end else r_baud <= r_baud + BAUD_GENISLIK'(1);
          end
          PARITE: begin
            if (w_bit_son) begin
              r_baud  <= '0;
              r_bit   <= '0;
              r_durum <= DURMA;
              r_tx    <= 1'b1;
            end else r_baud <= r_baud + BAUD_GENISLIK'(1);
          end
          DURMA: begin
            if (w_bit_son) begin
              r_baud <= '0;
              if (w_son_durma) begin
                r_bitti  <= 1'b1;
                r_mesgul <= 1'b0;
                r_durum  <= BOSTA;
              end else r_bit <= r_bit + BW'(1);
            end else r_baud <= r_baud + BAUD_GENISLIK'(1);
          end
          default: r_durum <= BOSTA;
        endcase
      end
    end
  end

  // Shift register and parity are datapath only; they reload on every pop.
  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_shift  <= w_fifo_veri;
      r_parite <= parite_hesapla(w_fifo_veri, parite_mod_i);
    end else if ((r_durum == VERI) && w_bit_son) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign tx_o         = r_tx;
  assign mesgul_o     = r_mesgul;
  assign bitti_o      = r_bitti;
  assign fifo_bos_o   = w_bos;
  assign fifo_dolu_o  = w_dolu;
  assign veri_hazir_o = !w_dolu;

endmodule

// File: tb/tb_uart_verici_param.sv
// Bench for uart_verici_param: written frames go to a scoreboard and a line
// monitor checks every cycle of each transmitted frame against it.
module tb_uart_verici_param;

  typedef struct {
    logic [7:0] d;
    int         p;
    logic [1:0] pm;
    logic       iki;
    int         nb;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        gec;
  logic [7:0]  veri;
  logic [15:0] baud;
  logic [1:0]  pm;
  logic        iki;
  logic        sel7;

  logic tx8, mes8, bit8, bos8, dol8, haz8;
  logic tx7, mes7, bit7, bos7, dol7, haz7;
  logic tx_s, mes_s, bit_s, bos_s, dol_s, haz_s;

  int     checks = 0;
  int     failures = 0;
  int     bitti_cnt = 0;
  int     gaps = 0;
  bit     mon_en = 1'b0;
  bit     mon_busy = 1'b0;
  frame_t sb[$];

  always #5 clk = ~clk;

  uart_verici_param #(.VERI_BIT(8), .FIFO_DERINLIK(4), .BAUD_GENISLIK(16)) dut8 (
    .clk_i(clk), .rst_i(rst), .veri_gecerli_i(gec && !sel7), .veri_i(veri),
    .veri_hazir_o(haz8), .baud_div_i(baud), .parite_mod_i(pm), .durma_iki_i(iki),
    .tx_o(tx8), .mesgul_o(mes8), .bitti_o(bit8), .fifo_bos_o(bos8), .fifo_dolu_o(dol8)
  );

  uart_verici_param #(.VERI_BIT(7), .FIFO_DERINLIK(4), .BAUD_GENISLIK(16)) dut7 (
    .clk_i(clk), .rst_i(rst), .veri_gecerli_i(gec && sel7), .veri_i(veri[6:0]),
    .veri_hazir_o(haz7), .baud_div_i(baud), .parite_mod_i(pm), .durma_iki_i(iki),
    .tx_o(tx7), .mesgul_o(mes7), .bitti_o(bit7), .fifo_bos_o(bos7), .fifo_dolu_o(dol7)
  );

  assign tx_s  = sel7 ? tx7  : tx8;
  assign mes_s = sel7 ? mes7 : mes8;
  assign bit_s = sel7 ? bit7 : bit8;
  assign bos_s = sel7 ? bos7 : bos8;
  assign dol_s = sel7 ? dol7 : dol8;
  assign haz_s = sel7 ? haz7 : haz8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input frame_t f);
    int par;
    par = (f.pm == 2'd1 || f.pm == 2'd2) ? 1 : 0;
    return 1 + f.nb + par + (f.iki ? 2 : 1);
  endfunction

  function automatic logic frame_bit(input frame_t f, input int idx);
    logic p;
    p = 1'b0;
    for (int i = 0; i < f.nb; i++) p = p ^ f.d[i];
    if (f.pm == 2'd2) p = ~p;
    if (idx == 0) return 1'b0;
    if (idx <= f.nb) return f.d[idx-1];
    if ((f.pm == 2'd1 || f.pm == 2'd2) && idx == f.nb + 1) return p;
    return 1'b1;
  endfunction

  always @(negedge clk) if (bit_s === 1'b1) bitti_cnt++;

  // Line monitor: each frame is checked cycle by cycle, then the end pulse.
  bit     m_at_edge = 1'b0;
  bit     m_abort;
  frame_t m_f;
  int     m_len;
  initial begin
    forever begin
      if (!m_at_edge) @(negedge clk);
      m_at_edge = 1'b0;
      if (mon_en && tx_s === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", 32'd0, 32'd1);
        end else begin
          m_f = sb.pop_front();
          mon_busy = 1'b1;
          m_len = frame_len(m_f) * m_f.p;
          m_abort = 1'b0;
          for (int c = 0; c < m_len; c++) begin
            if (c > 0) begin
              @(negedge clk);
              if (!mon_en) begin
                m_abort = 1'b1;
                break;
              end
              chk("bitti_inframe", bit_s, 1'b0);
            end
            chk($sformatf("tx_d%0h_bit%0d", m_f.d, c / m_f.p), tx_s, frame_bit(m_f, c / m_f.p));
          end
          if (!m_abort) begin
            @(negedge clk);
            chk("bitti_end", bit_s, 1'b1);
            if (sb.size() > 0 && tx_s !== 1'b0) gaps++;
            m_at_edge = 1'b1;
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, output int waited);
    frame_t f;
    waited = 0;
    @(negedge clk);
    gec  = 1'b1;
    veri = d;
    while (!haz_s && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("wr_timeout", (waited < 3000), 1'b1);
    f.d = d; f.p = (baud == 16'd0) ? 1 : int'(baud); f.pm = pm; f.iki = iki;
    f.nb = sel7 ? 7 : 8;
    sb.push_back(f);
    @(negedge clk);
    gec = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((sb.size() != 0 || mon_busy || mes_s) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (t < 5000), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  int w;
  int base;

  initial begin
    rst = 1'b1; gec = 1'b0; veri = 8'h00; baud = 16'd4; pm = 2'd0; iki = 1'b0; sel7 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx8, 1'b1);
    chk("rst_mesgul", mes8, 1'b0);
    chk("rst_bitti", bit8, 1'b0);
    chk("rst_bos", bos8, 1'b1);
    chk("rst_dolu", dol8, 1'b0);
    chk("rst_hazir", haz8, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // 8N1 at 4 cycles/bit, including pop latency.
    base = bitti_cnt;
    wr(8'h55, w);
    chk("lat_bos_after_push", bos8, 1'b0);
    chk("lat_tx_before_pop", tx8, 1'b1);
    @(negedge clk);
    chk("lat_tx_after_pop", tx8, 1'b0);
    chk("lat_mesgul", mes8, 1'b1);
    wait_idle("idle_8n1");
    chk("bitti_cnt_8n1", bitti_cnt - base, 1);

    // 7-bit, even parity, two stops.
    sel7 = 1'b1; pm = 2'd1; iki = 1'b1; baud = 16'd2;
    base = bitti_cnt;
    wr(8'h53, w);
    wait_idle("idle_7e2");
    chk("bitti_cnt_7e2", bitti_cnt - base, 1);
    sel7 = 1'b0; iki = 1'b0;

    // Odd parity, two queued words.
    pm = 2'd2; baud = 16'd3;
    wr(8'h01, w);
    wr(8'h00, w);
    wait_idle("idle_odd");

    // Back-pressure and back-to-back frames.
    pm = 2'd0; baud = 16'd2; gaps = 0;
    base = bitti_cnt;
    wr(8'hA1, w);
    wr(8'hB2, w);
    wr(8'hC3, w);
    wr(8'hD4, w);
    wr(8'hE5, w);
    chk("bp_dolu", dol8, 1'b1);
    chk("bp_hazir", haz8, 1'b0);
    wr(8'hF6, w);
    chk("bp_waited", (w > 0), 1'b1);
    wait_idle("idle_bp");
    chk("bp_bitti_cnt", bitti_cnt - base, 6);
    chk("bp_gaps", gaps, 0);

    // Reset during data bit 3 with a second word queued.
    mon_en = 1'b0; baud = 16'd4;
    wr(8'hA5, w);
    wr(8'h3C, w);
    repeat (16) @(negedge clk);
    chk("mid_mesgul", mes8, 1'b1);
    base = bitti_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", tx8, 1'b1);
    chk("mid_rst_mesgul", mes8, 1'b0);
    chk("mid_rst_bitti", bit8, 1'b0);
    chk("mid_rst_bos", bos8, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_bitti", bitti_cnt - base, 0);
    chk("mid_rst_idle_tx", tx8, 1'b1);
    sb.delete();
    mon_en = 1'b1;
    base = bitti_cnt;
    wr(8'hC3, w);
    wait_idle("idle_after_rst");
    chk("after_rst_bitti", bitti_cnt - base, 1);

    // Divider zero, then a divider change in mid-frame.
    baud = 16'd0;
    wr(8'h96, w);
    wait_idle("idle_div0");
    baud = 16'd3;
    wr(8'h5A, w);
    repeat (3) @(negedge clk);
    baud = 16'd7;
    wait_idle("idle_cfg_change");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", checks);
    $fatal(1, "timeout");
  end

endmodule
